// File: rtl/rpi_bus_pkg.sv
// rpi_bus_pkg: shared tag/selection encodings and counter width for the RPi bus memory arbiter
package rpi_bus_pkg;
    localparam int SAT_WIDTH = 32;
    typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_HOST = 2'd1, TAG_LOCAL = 2'd2} tag_t;
    typedef enum logic [2:0] {SEL_NONE, SEL_FORCE, SEL_HW, SEL_HR, SEL_LOCAL} sel_t;
endpackage

// File: rtl/rpi_bus_saturating_counter.sv
// rpi_bus_saturating_counter: event counter that sticks at all-ones
module rpi_bus_saturating_counter
    import rpi_bus_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_inc,
    output logic [SAT_WIDTH-1:0] o_count
);
    logic [SAT_WIDTH-1:0] r_count;
    always_ff @(posedge clock) begin
        if (reset) r_count <= '0;
        else if (i_inc && r_count != '1) r_count <= r_count + 1'b1;
    end
    assign o_count = r_count;
endmodule

// File: rtl/rpi_bus_memory_arbiter.sv
// rpi_bus_memory_arbiter: shares one single-port RAM between the host bus (write capture + read prefetch) and a local requester
module rpi_bus_memory_arbiter
    import rpi_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_DEPTH  = 14,
    parameter int LOCAL_MAX_WAIT = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     host_write_strobe,
    input  logic [ADDRESS_DEPTH-1:0] host_address,
    input  logic [DATA_WIDTH-1:0]    host_write_data,
    output logic [DATA_WIDTH-1:0]    host_read_data,
    input  logic                     local_req,
    input  logic                     local_write,
    input  logic [ADDRESS_DEPTH-1:0] local_address,
    input  logic [DATA_WIDTH-1:0]    local_write_data,
    output logic                     local_grant,
    output logic [DATA_WIDTH-1:0]    local_read_data,
    output logic                     local_read_valid,
    output logic                     mem_enable,
    output logic                     mem_write,
    output logic [ADDRESS_DEPTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data,
    output logic [SAT_WIDTH-1:0]     host_overrun_errors,
    output logic [SAT_WIDTH-1:0]     local_forced_slots
);
    localparam int WAIT_WIDTH = $clog2(LOCAL_MAX_WAIT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = WAIT_WIDTH'(LOCAL_MAX_WAIT);

    logic                     r_hw_pending;
    logic [ADDRESS_DEPTH-1:0] r_hw_address;
    logic [DATA_WIDTH-1:0]    r_hw_data;
    logic                     r_hr_stale;
    logic [ADDRESS_DEPTH-1:0] r_pf_address;
    tag_t                     r_tag;
    logic [WAIT_WIDTH-1:0]    r_wait;
    logic [DATA_WIDTH-1:0]    r_host_rdata;
    logic [DATA_WIDTH-1:0]    r_local_rdata;
    sel_t                     w_sel;
    logic                     w_local;
    logic                     w_host;
    logic                     w_wr_hit;
    logic                     w_capture;
    logic                     w_overrun;
    logic                     w_forced;

    // The prefetch is wanted whenever the host points elsewhere or the prefetched word went stale
    always_comb begin
        w_sel = SEL_NONE;
        if (reset) w_sel = SEL_NONE;
        else if (local_req && r_wait == WAIT_MAX) w_sel = SEL_FORCE;
        else if (r_hw_pending) w_sel = SEL_HW;
        else if (r_hr_stale || host_address != r_pf_address) w_sel = SEL_HR;
        else if (local_req) w_sel = SEL_LOCAL;
    end

    assign w_local          = w_sel == SEL_FORCE || w_sel == SEL_LOCAL;
    assign w_host           = w_sel == SEL_HW || w_sel == SEL_HR;
    assign w_forced         = w_sel == SEL_FORCE;
    assign mem_enable       = w_sel != SEL_NONE;
    assign mem_write        = w_local ? local_write : w_sel == SEL_HW;
    assign mem_address      = w_local ? local_address : w_sel == SEL_HW ? r_hw_address : w_sel == SEL_HR ? host_address : '0;
    assign mem_write_data   = w_local ? local_write_data : w_sel == SEL_HW ? r_hw_data : '0;
    assign local_grant      = w_local;
    assign w_wr_hit         = mem_write && mem_address == r_pf_address;
    assign w_capture        = r_tag == TAG_HOST && host_address == r_pf_address && !w_wr_hit;
    assign w_overrun        = host_write_strobe && r_hw_pending && w_sel != SEL_HW;
    assign host_read_data   = r_host_rdata;
    assign local_read_valid = !reset && r_tag == TAG_LOCAL;
    assign local_read_data  = local_read_valid ? mem_read_data : r_local_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hw_pending  <= 1'b0;
            r_hw_address  <= '0;
            r_hw_data     <= '0;
            r_hr_stale    <= 1'b1;
            r_pf_address  <= '0;
            r_tag         <= TAG_NONE;
            r_wait        <= '0;
            r_host_rdata  <= '0;
            r_local_rdata <= '0;
        end else begin
            r_hw_pending <= host_write_strobe || (r_hw_pending && w_sel != SEL_HW);
            if (host_write_strobe) begin
                r_hw_address <= host_address;
                r_hw_data    <= host_write_data;
            end
            r_hr_stale <= w_wr_hit || (r_hr_stale && w_sel != SEL_HR);
            if (w_sel == SEL_HR) r_pf_address <= host_address;
            r_tag <= w_sel == SEL_HR ? TAG_HOST : (w_local && !local_write) ? TAG_LOCAL : TAG_NONE;
            if (w_capture) r_host_rdata <= mem_read_data;
            if (r_tag == TAG_LOCAL) r_local_rdata <= mem_read_data;
            r_wait <= (!local_req || w_local) ? '0 : (w_host && r_wait != WAIT_MAX) ? r_wait + 1'b1 : r_wait;
        end
    end

    rpi_bus_saturating_counter u_overrun (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_overrun),
        .o_count (host_overrun_errors)
    );

    rpi_bus_saturating_counter u_forced (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_forced),
        .o_count (local_forced_slots)
    );
endmodule

// File: doc/rpi_bus_memory_arbiter.md
Name: rpi_bus_memory_arbiter

Overview:
- Sits between half_duplex_rpi_bus and one single-port synchronous RAM. Shares that RAM between the host (RPi via write_strobe/address_word_reg/read_data_word) and one local fabric requester.
- Captures host writes and prefetches host read data whenever the host address changes or the data at that address changes. read_data_word is therefore always valid before the host's next read transaction.
- Local requester uses a req/grant handshake with bounded starvation.

Parameters:
DATA_WIDTH, 32, RAM and bus data word width
ADDRESS_DEPTH, 14, RAM address bits (host uses the LSBs of address_word_reg)
LOCAL_MAX_WAIT, 4, max consecutive host services while local_req is held before local is forced a slot (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
host_write_strobe  input  1  one-cycle pulse from the bus write_strobe bit for this bank
host_address  input  ADDRESS_DEPTH  from address_word_reg
host_write_data  input  DATA_WIDTH  write_data_word
host_read_data  output  DATA_WIDTH  to read_data_word (registered)
local_req  input  1  local access request, held until granted
local_write  input  1  1=write, 0=read; sampled with local_req
local_address  input  ADDRESS_DEPTH  local address
local_write_data  input  DATA_WIDTH  local write data
local_grant  output  1  one-cycle pulse: request issued to RAM this cycle
local_read_data  output  DATA_WIDTH  local read result
local_read_valid  output  1  one-cycle pulse, one cycle after a local read grant
mem_enable  output  1  RAM enable
mem_write  output  1  RAM write enable
mem_address  output  ADDRESS_DEPTH  RAM address
mem_write_data  output  DATA_WIDTH  RAM write data
mem_read_data  input  DATA_WIDTH  RAM read data, valid one cycle after mem_enable & !mem_write
host_overrun_errors  output  32  count of host strobes arriving while a host write was still pending
local_forced_slots  output  32  count of starvation-forced local grants

Behaviour:
- Reset: all outputs 0, both counters 0, pending flags cleared, prefetch_address=0, prefetch_valid=0. Reset mid-access abandons the access; a pending capture-stage read result is discarded.
- Host write capture: on host_write_strobe, latch host_address and host_write_data into hw_address/hw_data and set hw_pending. If hw_pending is already set, the new values overwrite the old ones and host_overrun_errors increments (saturates at 2^32-1).
- Host read pending (hr_pending) is set when any of these holds:
  - host_address != prefetch_address;
  - prefetch_valid=0;
  - a write (host or local) is issued to prefetch_address.
- Arbitration, evaluated each cycle the RAM is free (one access issued per cycle), in priority order:
  1. forced local, when wait_count==LOCAL_MAX_WAIT and local_req;
  2. hw_pending;
  3. hr_pending;
  4. local_req.
- wait_count:
  - increments on each host issue while local_req=1;
  - clears on any local grant or when local_req=0;
  - saturates at LOCAL_MAX_WAIT.
- Issue cycle: mem_enable=1 with the selected address, data and write bit.
  - A host write clears hw_pending.
  - A host read clears hr_pending and records the issued address in prefetch_address.
  - A local issue pulses local_grant.
  - A forced local issue also increments local_forced_slots.
- Capture stage (one cycle later):
  - Host read: host_read_data <= mem_read_data and prefetch_valid <= 1. Discarded (hr_pending stays or re-sets) if host_address changed, or a write hit prefetch_address, during the in-flight cycle.
  - Local read: local_read_data <= mem_read_data and local_read_valid pulses.
  - Host and local reads may pipeline back-to-back; the capture stage carries a 2-bit tag (none/host/local).
- Latency:
  - Host write strobe to RAM write: 1–2 cycles (2 cycles if a forced local slot is due).
  - Address change to host_read_data update: 2 cycles when idle; worst case 3 + (pending host write).
- Simultaneous events:
  - Strobe and address change in the same cycle: both recorded; the write is serviced first, so the prefetch observes the new data.
  - Local write to prefetch_address in the same cycle as a host read of it: the host read is re-issued.
- Address wrap: host_address bits above ADDRESS_DEPTH are ignored by the instantiating top; no wrap handling is needed internally.

Decomposition:
- Shared package rpi_bus_pkg: arbiter state/tag encodings (TAG_NONE, TAG_HOST, TAG_LOCAL) and the saturating-increment width constant (32).
- One natural sub-module: rpi_bus_saturating_counter (32-bit, increment enable, synchronous reset), instantiated twice.
- Everything else stays flat.

Test Plan:
- Reset, then host_address=0x0005 with RAM[5]=0xDEADBEEF -> mem_enable on cycle 1 (addr 5, read); host_read_data=0xDEADBEEF on cycle 3; no further RAM access while idle.
- host_write_strobe with address 0x0010 and data 0x12345678, host_address held at 0x0010 -> RAM write cycle 1, re-prefetch read cycle 2, host_read_data=0x12345678 at cycle 4.
- Two strobes 1 cycle apart while local forced slot due (wait_count=LOCAL_MAX_WAIT) -> host_overrun_errors=1; only the second data word is written to RAM.
- local_req held with continuous host address changes, LOCAL_MAX_WAIT=4 -> local_grant on the 5th slot; local_forced_slots=1; local_read_valid exactly 1 cycle after local_grant.
- Local write 0xCAFEF00D to current prefetch_address -> hr_pending set; host_read_data=0xCAFEF00D within 3 cycles.
- Assert reset while a host read is in the capture stage -> host_read_data stays 0, all pulses 0, and counters 0 the next cycle.
